// File: rtl/nios_dbg_slave_pkg.sv
// nios_dbg_slave_pkg: shared widths, IR codes and command type
// for the sysclk-side debug slave command queue.
package nios_dbg_slave_pkg;

  localparam int DEF_SR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  localparam logic [DEF_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_WIDTH-1:0] ir;
    logic [DEF_SR_WIDTH-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/nios_dbg_slave_sync.sv
// nios_dbg_slave_sync: 2-flop synchroniser plus edge flop for a
// TCK-domain strobe; rise pulses one clk cycle per rising edge.
module nios_dbg_slave_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;
  logic v1, v2;
  logic armed;

  // A level already high at reset release is not an edge: rise is
  // only enabled once s2 has carried a genuine low sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      s3    <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & ~s2);
    end
  end

  assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/nios_dbg_slave_cmdq.sv
// nios_dbg_slave_cmdq: queues synchronised JTAG DR scans as commands.
// Define NIOS_DBG_SLAVE_OVF_CNT_EN to add the ovf_cnt drop counter.
module nios_dbg_slave_cmdq
  import nios_dbg_slave_pkg::*;
#(
  parameter int SR_WIDTH = DEF_SR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [IR_WIDTH-1:0]        act_ir,
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [2**IR_WIDTH-1:0]     take_action,
  output logic [2**IR_WIDTH-1:0]     take_no_action,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
  ,
  output logic [7:0]                 ovf_cnt
`endif
);

  localparam int NACT = 2**IR_WIDTH;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [SR_WIDTH-1:0] payload;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              head;
  logic [PW-1:0]       wptr, rptr;
  logic [IR_WIDTH-1:0] ir_lat;
  logic [NACT-1:0]     sel;
  logic                uir_rise, udr_rise;
  logic                pop, push, drop;

  nios_dbg_slave_sync u_uir (
    .clk   (clk),
    .reset (reset),
    .d     (vs_uir),
    .rise  (uir_rise)
  );

  nios_dbg_slave_sync u_udr (
    .clk   (clk),
    .reset (reset),
    .d     (vs_udr),
    .rise  (udr_rise)
  );

  assign head      = mem[rptr];
  assign act_valid = (cmd_count != '0);
  assign act_ir    = head.ir;
  assign jdo       = head.payload;
  assign sel       = NACT'(1) << act_ir;

  // A pop in the same cycle frees the slot for a push into a full queue.
  assign pop  = act_valid & act_ready;
  assign push = udr_rise & ((cmd_count < CW'(DEPTH)) | pop);
  assign drop = udr_rise & ~push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {ir_lat, sr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr           <= '0;
      rptr           <= '0;
      cmd_count      <= '0;
      ir_lat         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ovf            <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push & ~pop) begin
        cmd_count <= cmd_count + CW'(1);
      end else if (pop & ~push) begin
        cmd_count <= cmd_count - CW'(1);
      end
      if (uir_rise) ir_lat <= ir_in;
      take_action    <= (pop &  jdo[SR_WIDTH-1]) ? sel : '0;
      take_no_action <= (pop & ~jdo[SR_WIDTH-1]) ? sel : '0;
      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (drop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nios_dbg_slave_cmdq.sv
// tb_nios_dbg_slave_cmdq: random and directed scans checked against
// a queue-based reference model of the command path.
module tb_nios_dbg_slave_cmdq;
  import nios_dbg_slave_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic        act_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        act_valid;
  logic [1:0]  act_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  cmd_count;
  logic        ovf;
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
  int          m_oc;
`endif

  always #5 clk = ~clk;

  nios_dbg_slave_cmdq #(.SR_WIDTH(38), .IR_WIDTH(2), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_ir         (act_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_count      (cmd_count),
    .ovf            (ovf),
    .ovf_clr        (ovf_clr)
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    ,
    .ovf_cnt        (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a command queue fed by strobe edges seen in the
  // sampled level history since reset (edge = low then high sample,
  // acted upon two edges after the first high sample).
  logic [39:0] m_q[$];
  logic [1:0]  m_ir;
  logic        m_ovf;
  logic [3:0]  m_ta, m_tna;
  bit   [2:0]  uh, dh;
  int          un, dn;
  int          rdy_mode = 0;
  bit          clr_rand = 0;
  bit          clr_once = 0;

  function automatic void model_reset();
    m_q.delete();
    m_ir = '0; m_ovf = 1'b0; m_ta = '0; m_tna = '0;
    uh = '0; dh = '0; un = 0; dn = 0;
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    m_oc = 0;
`endif
  endfunction

  function automatic void model_edge();
    bit ur, dr, pop, acc;
    logic [39:0] h;
    ur = (un >= 3) && uh[1] && !uh[2];
    dr = (dn >= 3) && dh[1] && !dh[2];
    uh = {uh[1:0], vs_uir};
    dh = {dh[1:0], vs_udr};
    if (un < 3) un++;
    if (dn < 3) dn++;
    pop = (m_q.size() > 0) && act_ready;
    m_ta = '0;
    m_tna = '0;
    if (pop) begin
      h = m_q.pop_front();
      if (h[37]) m_ta[h[39:38]] = 1'b1;
      else       m_tna[h[39:38]] = 1'b1;
    end
    acc = dr && (m_q.size() < DEPTH);
    if (acc) m_q.push_back({m_ir, sr});
    if (ur) m_ir = ir_in;
    if (ovf_clr) begin
      m_ovf = 1'b0;
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
      m_oc = 0;
`endif
    end else if (dr && !acc) begin
      m_ovf = 1'b1;
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
      if (m_oc < 255) m_oc++;
`endif
    end
  endfunction

  task automatic check_all();
    check("valid", 64'(act_valid), 64'(m_q.size() > 0));
    check("count", 64'(cmd_count), 64'(m_q.size()));
    if (m_q.size() > 0) begin
      check("head_ir", 64'(act_ir), 64'(m_q[0][39:38]));
      check("head_jdo", 64'(jdo), 64'(m_q[0][37:0]));
    end
    check("take_action", 64'(take_action), 64'(m_ta));
    check("take_no_action", 64'(take_no_action), 64'(m_tna));
    check("ovf", 64'(ovf), 64'(m_ovf));
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    check("ovf_cnt", 64'(ovf_cnt), 64'(m_oc));
`endif
  endtask

  task automatic tick();
    if (rdy_mode == 1) act_ready = 1'($urandom_range(0, 1));
    ovf_clr = clr_once || (clr_rand && $urandom_range(0, 15) == 0);
    clr_once = 0;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic uir_scan(input logic [1:0] ir, input int hi, input int lo);
    ir_in = ir;
    vs_uir = 1'b1;
    repeat (hi) tick();
    vs_uir = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic udr_scan(input logic [37:0] d, input int hi, input int lo);
    sr = d;
    vs_udr = 1'b1;
    repeat (hi) tick();
    vs_udr = 1'b0;
    repeat (lo) tick();
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);
    repeat (3) tick();
    check("rst_valid", 64'(act_valid), 64'd0);
    check("rst_count", 64'(cmd_count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    // Break command with bit 37 set, latency and action pulse
    uir_scan(IR_BREAK, 3, 3);
    sr = 38'h20_0000_0001;
    vs_udr = 1'b1;
    tick();
    tick();
    check("t1_not_yet", 64'(act_valid), 64'd0);
    tick();
    check("t1_valid", 64'(act_valid), 64'd1);
    check("t1_ir", 64'(act_ir), 64'(IR_BREAK));
    check("t1_jdo", 64'(jdo), 64'h20_0000_0001);
    tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    act_ready = 1'b1;
    tick();
    check("t1_ta", 64'(take_action), 64'b0100);
    act_ready = 1'b0;
    tick();
    check("t1_ta_off", 64'(take_action), 64'd0);

    // No-action command on IR 1
    uir_scan(IR_TRACEMEM, 3, 3);
    udr_scan(38'h0F_1234_5678, 3, 3);
    act_ready = 1'b1;
    tick();
    check("t2_tna", 64'(take_no_action), 64'b0010);
    check("t2_ta", 64'(take_action), 64'd0);
    act_ready = 1'b0;
    tick();

    // Overflow: five scans into a depth-4 queue
    for (int i = 0; i < 5; i++) udr_scan(rnd38(), 3, 3);
    check("t3_count", 64'(cmd_count), 64'd4);
    check("t3_ovf", 64'(ovf), 64'd1);
`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    check("t3_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
    act_ready = 1'b1;
    repeat (5) tick();
    act_ready = 1'b0;
    check("t3_drained", 64'(cmd_count), 64'd0);

    // Push into a full queue with a simultaneous pop
    clr_once = 1;
    tick();
    for (int i = 0; i < 4; i++) udr_scan(rnd38(), 3, 3);
    sr = rnd38();
    vs_udr = 1'b1;
    tick();
    tick();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    check("t4_count", 64'(cmd_count), 64'd4);
    check("t4_ovf", 64'(ovf), 64'd0);
    tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    act_ready = 1'b1;
    repeat (5) tick();
    act_ready = 1'b0;

    // Coincident uir/udr edges: push uses the previous ir_lat
    uir_scan(IR_TRACEMEM, 3, 3);
    ir_in = IR_TRACECTRL;
    sr = rnd38();
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (3) tick();
    udr_scan(rnd38(), 3, 3);
    check("t5_count", 64'(cmd_count), 64'd2);
    check("t5_ir_old", 64'(act_ir), 64'(IR_TRACEMEM));
    act_ready = 1'b1;
    tick();
    check("t5_ir_new", 64'(act_ir), 64'(IR_TRACECTRL));
    tick();
    act_ready = 1'b0;
    tick();

    // Reset with queued commands and vs_udr held high through release
    for (int i = 0; i < 3; i++) udr_scan(rnd38(), 3, 3);
    sr = rnd38();
    vs_udr = 1'b1;
    tick();
    do_reset(3);
    repeat (6) tick();
    check("t6_count", 64'(cmd_count), 64'd0);
    check("t6_valid", 64'(act_valid), 64'd0);
    vs_udr = 1'b0;
    repeat (3) tick();
    check("t6_no_push", 64'(cmd_count), 64'd0);
    udr_scan(rnd38(), 3, 3);
    check("t6_push", 64'(cmd_count), 64'd1);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;

    // Randomised scans with random back-pressure and clears
    rdy_mode = 1;
    clr_rand = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ir_in = 2'($urandom_range(0, 3));
        sr = rnd38();
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        repeat ($urandom_range(3, 5)) tick();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat ($urandom_range(3, 5)) tick();
      end else begin
        if ($urandom_range(0, 1) == 1)
          uir_scan(2'($urandom_range(0, 3)), $urandom_range(3, 5),
                   $urandom_range(3, 5));
        udr_scan(rnd38(), $urandom_range(3, 5), $urandom_range(3, 5));
      end
    end
    rdy_mode = 0;
    clr_rand = 0;
    act_ready = 1'b1;
    repeat (6) tick();
    check("final_empty", 64'(cmd_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
